// File: rtl/iec_cmd_decoder_pkg.sv
// Shared definitions for the IEC command decoder: widths, command codes, payload types
// and the command classifier.
package iec_cmd_decoder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CHAN_W = 4;

    localparam logic [BYTE_W-1:0] CMD_LISTEN   = 8'h20;
    localparam logic [BYTE_W-1:0] CMD_UNLISTEN = 8'h3F;
    localparam logic [BYTE_W-1:0] CMD_TALK     = 8'h40;
    localparam logic [BYTE_W-1:0] CMD_UNTALK   = 8'h5F;
    localparam logic [BYTE_W-1:0] CMD_SECOND   = 8'h60;
    localparam logic [BYTE_W-1:0] CMD_CLOSE    = 8'hE0;
    localparam logic [BYTE_W-1:0] CMD_OPEN     = 8'hF0;

    // Primary commands carry a 5-bit address, secondaries a 4-bit channel.
    localparam logic [BYTE_W-1:0] PRI_MASK = 8'hE0;
    localparam logic [BYTE_W-1:0] SEC_MASK = 8'hF0;

    // Address 31 is the UNLISTEN/UNTALK code and never names a device.
    localparam logic [ADDR_W-1:0] ADDR_NONE = 5'h1F;

    typedef enum logic [3:0] {
        CK_LISTEN,
        CK_UNLISTEN,
        CK_TALK,
        CK_UNTALK,
        CK_SECOND,
        CK_CLOSE,
        CK_OPEN,
        CK_UNKNOWN
    } cmd_kind_e;

    typedef struct packed {
        logic              listen;
        logic              talk;
        logic              addr_frame;
        logic              open_mode;
        logic [CHAN_W-1:0] channel;
    } dec_state_t;

    typedef struct packed {
        logic open_strobe;
        logic close_strobe;
        logic data_valid;
        logic turnaround;
        logic unknown_cmd;
    } dec_pulse_t;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [CHAN_W-1:0] chan;
        logic              is_name;
    } data_out_t;

    function automatic cmd_kind_e classify_cmd(input logic [BYTE_W-1:0] b);
        cmd_kind_e k;
        k = CK_UNKNOWN;
        if (b == CMD_UNLISTEN)                  k = CK_UNLISTEN;
        else if (b == CMD_UNTALK)               k = CK_UNTALK;
        else if ((b & PRI_MASK) == CMD_LISTEN)  k = CK_LISTEN;
        else if ((b & PRI_MASK) == CMD_TALK)    k = CK_TALK;
        else if ((b & SEC_MASK) == CMD_SECOND)  k = CK_SECOND;
        else if ((b & SEC_MASK) == CMD_CLOSE)   k = CK_CLOSE;
        else if ((b & SEC_MASK) == CMD_OPEN)    k = CK_OPEN;
        return k;
    endfunction

endpackage

// File: rtl/iec_sync.sv
// N-flop level synchroniser; resets to 1 so an idle (released) bus line is assumed.
module iec_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/iec_cmd_decoder.sv
// IEC bus command decoder: tracks listener/talker addressing and channel from ATN
// commands and forwards listener data bytes tagged with channel and filename flag.
module iec_cmd_decoder
    import iec_cmd_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic              atn,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_ready,
    output logic              listen_active,
    output logic              talk_active,
    output logic [CHAN_W-1:0] channel,
    output logic              open_strobe,
    output logic              close_strobe,
    output logic              data_valid,
    output logic [BYTE_W-1:0] data_byte,
    output logic [CHAN_W-1:0] data_chan,
    output logic              data_is_name,
    output logic              turnaround,
    output logic              unknown_cmd
);

    logic       atn_sync;
    logic       atn_s;
    logic       atn_fall_c;
    logic       atn_rise_c;
    logic       is_cmd_c;
    logic       is_data_c;
    logic       addr_hit_c;
    cmd_kind_e  kind_c;

    dec_state_t st_q, st_d;
    dec_pulse_t pl_q, pl_d;
    data_out_t  do_q, do_d;

    iec_sync #(
        .STAGES (SYNC_STAGES)
    ) u_atn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (atn),
        .q     (atn_sync)
    );

    // atn_s holds the settled level; an edge is seen the cycle before it updates,
    // so a byte arriving on an edge is classified by the pre-edge level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atn_s <= 1'b1;
        end else begin
            atn_s <= atn_sync;
        end
    end

    assign atn_fall_c = atn_s & ~atn_sync;
    assign atn_rise_c = ~atn_s & atn_sync;
    assign is_cmd_c   = rx_ready & ~atn_s;
    assign is_data_c  = rx_ready & atn_s;
    assign kind_c     = classify_cmd(rx_byte);
    assign addr_hit_c = (rx_byte[ADDR_W-1:0] == dev_addr) && (dev_addr != ADDR_NONE);

    // Next-state: ATN edge clears first, so command decode in the same cycle wins.
    always_comb begin
        st_d = st_q;
        pl_d = '0;
        do_d = do_q;

        if (atn_fall_c) begin
            st_d.open_mode  = 1'b0;
            st_d.addr_frame = 1'b0;
        end

        if (atn_rise_c && st_q.talk) begin
            pl_d.turnaround = 1'b1;
        end

        if (is_cmd_c) begin
            case (kind_c)
                CK_LISTEN: begin
                    if (addr_hit_c) begin
                        st_d.listen     = 1'b1;
                        st_d.talk       = 1'b0;
                        st_d.addr_frame = 1'b1;
                    end
                end
                CK_UNLISTEN: begin
                    st_d.listen     = 1'b0;
                    st_d.addr_frame = 1'b0;
                end
                CK_TALK: begin
                    if (addr_hit_c) begin
                        st_d.talk       = 1'b1;
                        st_d.listen     = 1'b0;
                        st_d.addr_frame = 1'b1;
                    end else begin
                        st_d.talk       = 1'b0;
                        st_d.addr_frame = 1'b0;
                    end
                end
                CK_UNTALK: begin
                    st_d.talk       = 1'b0;
                    st_d.addr_frame = 1'b0;
                end
                CK_SECOND: begin
                    if (st_q.addr_frame) begin
                        st_d.channel = rx_byte[CHAN_W-1:0];
                    end
                end
                CK_CLOSE: begin
                    if (st_q.addr_frame) begin
                        st_d.channel      = rx_byte[CHAN_W-1:0];
                        pl_d.close_strobe = 1'b1;
                    end
                end
                CK_OPEN: begin
                    if (st_q.addr_frame) begin
                        st_d.channel     = rx_byte[CHAN_W-1:0];
                        st_d.open_mode   = 1'b1;
                        pl_d.open_strobe = 1'b1;
                    end
                end
                default: begin
                    pl_d.unknown_cmd = 1'b1;
                end
            endcase
        end

        if (is_data_c && st_q.listen) begin
            pl_d.data_valid = 1'b1;
            do_d.data       = rx_byte;
            do_d.chan       = st_q.channel;
            do_d.is_name    = st_q.open_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            pl_q <= '0;
            do_q <= '0;
        end else begin
            st_q <= st_d;
            pl_q <= pl_d;
            do_q <= do_d;
        end
    end

    assign listen_active = st_q.listen;
    assign talk_active   = st_q.talk;
    assign channel       = st_q.channel;
    assign open_strobe   = pl_q.open_strobe;
    assign close_strobe  = pl_q.close_strobe;
    assign data_valid    = pl_q.data_valid;
    assign turnaround    = pl_q.turnaround;
    assign unknown_cmd   = pl_q.unknown_cmd;
    assign data_byte     = do_q.data;
    assign data_chan     = do_q.chan;
    assign data_is_name  = do_q.is_name;

endmodule

// File: tb/tb_iec_cmd_decoder.sv
// Bench for iec_cmd_decoder: directed bus sequences plus random commands/data,
// checked against a transaction-level model of the IEC addressing rules.
module tb_iec_cmd_decoder;

    localparam logic [4:0] DEV = 5'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       atn;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       listen_active;
    logic       talk_active;
    logic [3:0] channel;
    logic       open_strobe;
    logic       close_strobe;
    logic       data_valid;
    logic [7:0] data_byte;
    logic [3:0] data_chan;
    logic       data_is_name;
    logic       turnaround;
    logic       unknown_cmd;

    always #5 clk = ~clk;

    iec_cmd_decoder #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dev_addr      (DEV),
        .atn           (atn),
        .rx_byte       (rx_byte),
        .rx_ready      (rx_ready),
        .listen_active (listen_active),
        .talk_active   (talk_active),
        .channel       (channel),
        .open_strobe   (open_strobe),
        .close_strobe  (close_strobe),
        .data_valid    (data_valid),
        .data_byte     (data_byte),
        .data_chan     (data_chan),
        .data_is_name  (data_is_name),
        .turnaround    (turnaround),
        .unknown_cmd   (unknown_cmd)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: cumulative counts and the last forwarded data byte.
    int unsigned n_dv = 0, n_open = 0, n_close = 0, n_turn = 0, n_unk = 0;
    logic [7:0]  last_byte = '0;
    logic [3:0]  last_chan = '0;
    logic        last_name = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            n_dv++;
            last_byte = data_byte;
            last_chan = data_chan;
            last_name = data_is_name;
        end
        if (open_strobe)  n_open++;
        if (close_strobe) n_close++;
        if (turnaround)   n_turn++;
        if (unknown_cmd)  n_unk++;
    end

    // Reference model state and expected cumulative pulse counts.
    bit          m_listen, m_talk, m_frame, m_open, m_atn;
    int unsigned m_chan;
    int unsigned e_dv = 0, e_open = 0, e_close = 0, e_turn = 0, e_unk = 0;
    int unsigned e_byte = 0, e_chan = 0;
    bit          e_name = 1'b0;

    task automatic model_reset();
        m_listen = 0; m_talk = 0; m_frame = 0; m_open = 0; m_chan = 0;
    endtask

    task automatic model_byte(input int unsigned b);
        if (m_atn) begin
            if (m_listen) begin
                e_dv++; e_byte = b; e_chan = m_chan; e_name = m_open;
            end
        end else if (b == 'h3F) begin
            m_listen = 0; m_frame = 0;
        end else if (b == 'h5F) begin
            m_talk = 0; m_frame = 0;
        end else if (b >= 'h20 && b <= 'h3E) begin
            if (b - 'h20 == int'(DEV)) begin
                m_listen = 1; m_talk = 0; m_frame = 1;
            end
        end else if (b >= 'h40 && b <= 'h5E) begin
            if (b - 'h40 == int'(DEV)) begin
                m_talk = 1; m_listen = 0; m_frame = 1;
            end else begin
                m_talk = 0; m_frame = 0;
            end
        end else if (b >= 'h60 && b <= 'h6F) begin
            if (m_frame) m_chan = b - 'h60;
        end else if (b >= 'hE0 && b <= 'hEF) begin
            if (m_frame) begin m_chan = b - 'hE0; e_close++; end
        end else if (b >= 'hF0) begin
            if (m_frame) begin m_chan = b - 'hF0; e_open++; m_open = 1; end
        end else begin
            e_unk++;
        end
    endtask

    task automatic verify(input string ctx);
        check({ctx, ".listen"}, 32'(listen_active), 32'(m_listen));
        check({ctx, ".talk"},   32'(talk_active),   32'(m_talk));
        check({ctx, ".chan"},   32'(channel),       m_chan);
        check({ctx, ".n_dv"},   n_dv,    e_dv);
        check({ctx, ".n_open"}, n_open,  e_open);
        check({ctx, ".n_close"},n_close, e_close);
        check({ctx, ".n_turn"}, n_turn,  e_turn);
        check({ctx, ".n_unk"},  n_unk,   e_unk);
        check({ctx, ".dbyte"},  32'(last_byte), e_byte);
        check({ctx, ".dchan"},  32'(last_chan), e_chan);
        check({ctx, ".dname"},  32'(last_name), 32'(e_name));
    endtask

    task automatic send(input logic [7:0] b, input string ctx);
        @(negedge clk);
        rx_byte  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (29) @(negedge clk);
        model_byte(int'(b));
        verify(ctx);
    endtask

    task automatic set_atn(input bit v, input string ctx);
        @(negedge clk);
        atn = v;
        repeat (30) @(negedge clk);
        if (v != m_atn) begin
            if (!v) begin
                m_frame = 0; m_open = 0;
            end else if (m_talk) begin
                e_turn++;
            end
            m_atn = v;
        end
        verify(ctx);
    endtask

    task automatic check_all_zero(input string ctx);
        check({ctx, ".outs"}, 32'({listen_active, talk_active, channel, open_strobe, close_strobe,
                                   data_valid, data_byte, data_chan, data_is_name, turnaround,
                                   unknown_cmd}), 32'd0);
    endtask

    function automatic logic [7:0] gen_byte();
        logic [7:0] b;
        case ($urandom_range(0, 7))
            0: b = 8'($urandom_range(0, 255));
            1: b = 8'h28;
            2: b = 8'h20 | 8'($urandom_range(0, 31));
            3: b = 8'h3F;
            4: b = ($urandom_range(0, 1) == 0) ? 8'h48 : (8'h40 | 8'($urandom_range(0, 31)));
            5: b = 8'h5F;
            6: b = 8'h60 | 8'($urandom_range(0, 15));
            default: b = (($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0) | 8'($urandom_range(0, 15));
        endcase
        return b;
    endfunction

    initial begin
        rst_n = 1'b0; atn = 1'b1; rx_ready = 1'b0; rx_byte = '0;
        m_atn = 1; model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: listen + SECOND 8, two data bytes
        set_atn(0, "t1.atn0"); send(8'h28, "t1.listen"); send(8'h68, "t1.second");
        set_atn(1, "t1.atn1"); send(8'h42, "t1.d0"); send(8'h43, "t1.d1");
        // 2: OPEN channel 2 with filename bytes, then ATN clears open mode
        set_atn(0, "t2.atn0"); send(8'h28, "t2.listen"); send(8'hF2, "t2.open");
        set_atn(1, "t2.atn1"); send(8'h41, "t2.nameA"); send(8'h42, "t2.nameB");
        set_atn(0, "t2.atn0b"); set_atn(1, "t2.atn1b"); send(8'h99, "t2.data");
        // 3: talk, turnaround, untalk
        set_atn(0, "t3.atn0"); send(8'h48, "t3.talk"); send(8'h62, "t3.second");
        set_atn(1, "t3.atn1"); set_atn(0, "t3.atn0b"); send(8'h5F, "t3.untalk");
        // 4: other device addressed
        send(8'h3F, "t4.unl"); send(8'h29, "t4.listen9"); send(8'h68, "t4.second");
        set_atn(1, "t4.atn1"); send(8'h55, "t4.data");
        // 5: close, unlisten, unknown
        set_atn(0, "t5.atn0"); send(8'h28, "t5.listen"); send(8'hE3, "t5.close");
        send(8'h3F, "t5.unl"); send(8'h90, "t5.unk");
        // 6: reset mid-byte while listening
        send(8'h28, "t6.listen"); set_atn(1, "t6.atn1");
        @(negedge clk);
        rx_byte = 8'h77; rx_ready = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rx_ready = 1'b0;
        check_all_zero("t6.rst_a");
        repeat (2) @(negedge clk);
        check_all_zero("t6.rst_b");
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        send(8'h55, "t6.drop");

        // Random mix of ATN toggles, commands and data
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 2) set_atn(!m_atn, "rnd.atn");
            else send(gen_byte(), "rnd.byte");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
